// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the boot-loadable instruction memory
package imem_pkg;
  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW = 8;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;
endpackage

// File: rtl/imem_byte_ram.sv
// imem_byte_ram: byte-wide write port, combinational little-endian word read port
module imem_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-3:0] word_addr,
  output logic [31:0]   rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = {mem[{word_addr, 2'd3}], mem[{word_addr, 2'd2}],
                  mem[{word_addr, 2'd1}], mem[{word_addr, 2'd0}]};
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: instruction memory with a byte-stream loader that holds the core
// in reset while a program is written in
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW = IMEM_AW,
  parameter int BOOT_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        ce,
  output logic [31:0] i_data,
  input  logic        ld_start,
  input  logic [8:0]  ld_len,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        core_hold
);
  state_t state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW:0] remaining, len_clip;
  logic [31:0] word;
  logic we, unused_addr;
  assign unused_addr = ^{i_addr[31:AW], i_addr[1:0]};
  assign len_clip = (int'(ld_len) > DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(ld_len);
  assign we = state == S_LOAD && ld_valid;
  imem_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we(we), .waddr(ptr), .wdata(ld_byte),
    .word_addr(i_addr[AW-1:2]), .rdata(word)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= (BOOT_HOLD != 0) ? S_IDLE : S_RUN;
      ptr <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE || state == S_RUN) && ld_start) begin
        ptr <= '0;
        remaining <= len_clip;
      end else if (we) begin
        ptr <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  // a zero-length load skips LOAD entirely so no handshake can ever write
  always_comb begin
    state_nxt = state;
    if (state == S_DONE) state_nxt = S_RUN;
    else if (state == S_LOAD) state_nxt = (ld_valid && remaining == (AW+1)'(1)) ? S_DONE : S_LOAD;
    else if (ld_start) state_nxt = (len_clip == '0) ? S_DONE : S_LOAD;
    ld_ready = state == S_LOAD;
    ld_done = state == S_DONE;
    core_hold = state != S_RUN;
    i_data = (ce && !core_hold) ? word : NOP_INSN;
  end
endmodule
